// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared constants and types for the instruction-cache AXI read bridge.
package icache_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP,
        ST_DRAIN
    } bridge_state_e;

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// Cache request/return signals plus the AXI read channels, named from the bridge's side.
interface icache_axi_rd_bridge_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                flush_i;
    logic                addr_valid_i;
    logic [31:0]         addr_i;
    logic [7:0]          data_len_i;
    logic                resp_ready_o;
    logic                data_valid_o;
    logic [31:0]         data_o;
    logic                err_o;

    logic                arvalid_o;
    logic                arready_i;
    logic [31:0]         araddr_o;
    logic [7:0]          arlen_o;
    logic [2:0]          arsize_o;
    logic [1:0]          arburst_o;
    logic [ID_WIDTH-1:0] arid_o;

    logic                rvalid_i;
    logic                rready_o;
    logic [31:0]         rdata_i;
    logic [1:0]          rresp_i;
    logic                rlast_i;
    logic [ID_WIDTH-1:0] rid_i;

    // master: the bridge itself; slave: the cache plus AXI memory side around it
    modport master (
        input  flush_i, addr_valid_i, addr_i, data_len_i,
        output resp_ready_o, data_valid_o, data_o, err_o,
        output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, arid_o,
        input  arready_i,
        input  rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        output rready_o
    );

    modport slave (
        output flush_i, addr_valid_i, addr_i, data_len_i,
        input  resp_ready_o, data_valid_o, data_o, err_o,
        input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, arid_o,
        output arready_i,
        output rvalid_i, rdata_i, rresp_i, rlast_i, rid_i,
        input  rready_o
    );

endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one cache read request into one AXI INCR burst and returns the beats,
// one registered word per cycle; beats of a flushed request are discarded.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a cache request
// ST_AR    | AR channel valid, waiting for arready
// ST_R     | receiving beats and forwarding them to the cache
// ST_RESP  | zero-length request: accept pulse, no AXI traffic
// ST_DRAIN | flushed: consuming remaining beats without forwarding
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned         ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0,
    parameter int unsigned         MAX_LEN  = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    icache_axi_rd_bridge_if.master   bus
);

    if (MAX_LEN > 256) begin : g_bad_max_len
        $error("MAX_LEN must fit an 8-bit arlen");
    end

    bridge_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic [31:0]   data_q;
    logic          data_valid_q;
    logic          err_q;

    logic          arvalid;
    logic          rready;
    logic          resp_ready;
    logic          beat_fwd;
    logic          beat_err;
    logic          last_beat;

    // rid is ignored: only one transaction is ever outstanding
    logic          unused_rid;
    assign unused_rid = ^bus.rid_i;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        resp_ready   = 1'b0;
        beat_fwd     = 1'b0;
        beat_err     = 1'b0;
        last_beat    = (cnt_q == len_q - 8'd1);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.addr_valid_i) begin
                    addr_d       = bus.addr_i;
                    len_d        = bus.data_len_i;
                    cnt_d        = 8'd0;
                    flush_pend_d = 1'b0;
                    state_d      = (bus.data_len_i == 8'd0) ? ST_RESP : ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                // arvalid cannot be withdrawn, so a flush here is remembered
                if (bus.flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.arready_i) begin
                    resp_ready = 1'b1;
                    state_d    = (flush_pend_q || bus.flush_i) ? ST_DRAIN : ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (bus.rvalid_i) begin
                    cnt_d    = cnt_q + 8'd1;
                    beat_fwd = !bus.flush_i;
                    beat_err = (bus.rresp_i != AXI_RESP_OKAY) || (bus.rlast_i != last_beat);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else if (bus.flush_i) begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus.flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rready = 1'b1;
                if (bus.rvalid_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                resp_ready = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            data_valid_q <= beat_fwd;
            err_q        <= beat_fwd && beat_err;
            if (beat_fwd) begin
                data_q <= bus.rdata_i;
            end
        end
    end

    assign bus.arvalid_o    = arvalid;
    assign bus.araddr_o     = arvalid ? addr_q : '0;
    assign bus.arlen_o      = arvalid ? (len_q - 8'd1) : '0;
    assign bus.arsize_o     = AXI_SIZE_4B;
    assign bus.arburst_o    = AXI_BURST_INCR;
    assign bus.arid_o       = AXI_ID;
    assign bus.rready_o     = rready;
    assign bus.resp_ready_o = resp_ready;
    assign bus.data_valid_o = data_valid_q;
    assign bus.data_o       = data_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge: vector table of bursts, a data
// scoreboard, and hand-written zero-length and reset-mid-burst sequences.
module tb_icache_axi_rd_bridge;
    import icache_axi_rd_bridge_pkg::*;

    localparam int unsigned     ID_W    = 4;
    localparam logic [ID_W-1:0] AXI_ID  = 4'h5;
    localparam int unsigned     MAX_LEN = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_axi_rd_bridge_if #(.ID_WIDTH(ID_W)) bus ();

    icache_axi_rd_bridge #(
        .ID_WIDTH (ID_W),
        .AXI_ID   (AXI_ID),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          ar_stall;
        int          flush_ar;
        int          flush_beat;
        int          err_beat;
        int          early_last;
        int          drop_last;
        logic [31:0] base;
        int          exp_fwd;
        int          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   mon_fwd  = 0;
    int   mon_err  = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always @(posedge clk) cycle++;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && bus.addr_valid_i === 1'b1)
            assert (bus.data_len_i <= MAX_LEN) else $error("data_len_i above MAX_LEN");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.data_valid_o === 1'b1) begin
                mon_fwd++;
                if (bus.err_o === 1'b1) mon_err++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: data_valid_o with data 0x%0h, expected none", bus.data_o);
                end else begin
                    e = sb.pop_front();
                    chk("data_o", bus.data_o, e.data);
                    chk("err_o", {31'd0, bus.err_o}, {31'd0, e.err});
                    chk("data_lag", cycle, e.cyc + 1);
                end
            end else if (bus.err_o !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL err_without_valid: err_o=%b expected 0", bus.err_o);
            end
        end
    end

    task automatic idle_inputs();
        bus.flush_i      = 1'b0;
        bus.addr_valid_i = 1'b0;
        bus.addr_i       = '0;
        bus.data_len_i   = '0;
        bus.arready_i    = 1'b0;
        bus.rvalid_i     = 1'b0;
        bus.rdata_i      = '0;
        bus.rresp_i      = 2'b00;
        bus.rlast_i      = 1'b0;
        bus.rid_i        = AXI_ID;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'd0, bus.arvalid_o}, 32'd0);
        chk({tag, "_rready"}, {31'd0, bus.rready_o}, 32'd0);
        chk({tag, "_resp_ready"}, {31'd0, bus.resp_ready_o}, 32'd0);
        chk({tag, "_data_valid"}, {31'd0, bus.data_valid_o}, 32'd0);
        chk({tag, "_data"}, bus.data_o, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err_o}, 32'd0);
        chk({tag, "_araddr"}, bus.araddr_o, 32'd0);
        chk({tag, "_arlen"}, {24'd0, bus.arlen_o}, 32'd0);
        chk({tag, "_arsize"}, {29'd0, bus.arsize_o}, 32'd2);
        chk({tag, "_arburst"}, {30'd0, bus.arburst_o}, 32'd1);
        chk({tag, "_arid"}, {28'd0, bus.arid_o}, 32'd5);
    endtask

    // Entered and left at posedge+1; ends in R or DRAIN just after the AR handshake.
    task automatic do_req_ar(input logic [31:0] addr, input logic [7:0] len,
                             input int stall, input int flush_ar);
        bus.addr_valid_i = 1'b1;
        bus.addr_i       = addr;
        bus.data_len_i   = len;
        @(negedge clk);
        chk("arvalid_req_cycle", {31'd0, bus.arvalid_o}, 32'd0);
        @(posedge clk); #1;
        bus.addr_valid_i = 1'b0;
        for (int k = 0; k <= stall; k++) begin
            bus.arready_i = (k == stall);
            bus.flush_i   = (flush_ar != 0) && (k == 0);
            @(negedge clk);
            chk("arvalid", {31'd0, bus.arvalid_o}, 32'd1);
            chk("araddr", bus.araddr_o, addr);
            chk("arlen", {24'd0, bus.arlen_o}, {24'd0, len - 8'd1});
            chk("arsize", {29'd0, bus.arsize_o}, 32'd2);
            chk("arburst", {30'd0, bus.arburst_o}, 32'd1);
            chk("arid", {28'd0, bus.arid_o}, 32'd5);
            chk("resp_ready_ar", {31'd0, bus.resp_ready_o}, (k == stall) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        bus.arready_i = 1'b0;
        bus.flush_i   = 1'b0;
    endtask

    task automatic run_beats(input vec_t v);
        bit   drain;
        logic last_b;
        logic rl;
        exp_t e;
        drain = (v.flush_ar != 0);
        for (int b = 0; b < int'(v.len); b++) begin
            last_b = (b == int'(v.len) - 1);
            rl = last_b;
            if (b == v.early_last) rl = 1'b1;
            if (last_b && v.drop_last != 0) rl = 1'b0;
            bus.rvalid_i     = 1'b1;
            bus.rdata_i      = v.base + b;
            bus.rresp_i      = (b == v.err_beat) ? 2'b10 : 2'b00;
            bus.rlast_i      = rl;
            bus.flush_i      = (b == v.flush_beat);
            // a competing request while draining must not be taken
            bus.addr_valid_i = drain;
            bus.addr_i       = 32'hDEAD_0000;
            bus.data_len_i   = 8'd1;
            if (!drain && b != v.flush_beat) begin
                e.data = v.base + b;
                e.err  = (b == v.err_beat) || (rl != last_b);
                e.cyc  = cycle;
                sb.push_back(e);
            end
            @(negedge clk);
            chk("rready", {31'd0, bus.rready_o}, 32'd1);
            chk("arvalid_in_r", {31'd0, bus.arvalid_o}, 32'd0);
            chk("resp_ready_in_r", {31'd0, bus.resp_ready_o}, 32'd0);
            @(posedge clk); #1;
            if (b == v.flush_beat) drain = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic zero_len_req(input logic [31:0] addr);
        bus.addr_valid_i = 1'b1;
        bus.addr_i       = addr;
        bus.data_len_i   = 8'd0;
        @(negedge clk);
        chk("zl_resp_req_cycle", {31'd0, bus.resp_ready_o}, 32'd0);
        @(posedge clk); #1;
        bus.addr_valid_i = 1'b0;
        @(negedge clk);
        chk("zl_resp_ready", {31'd0, bus.resp_ready_o}, 32'd1);
        chk("zl_arvalid", {31'd0, bus.arvalid_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("zl_resp_after", {31'd0, bus.resp_ready_o}, 32'd0);
            chk("zl_arvalid_after", {31'd0, bus.arvalid_o}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        //            addr          len   stl fAR fBeat err  early drop base    fwd err
        vecs[0] = '{32'h1C00_0020, 8'd8, 0,  0,  -1,  -1,  -1,  0,  32'hA0, 8,  0};
        vecs[1] = '{32'h2000_0100, 8'd2, 3,  0,  -1,  -1,  -1,  0,  32'h11, 2,  0};
        vecs[2] = '{32'h3000_0040, 8'd8, 0,  0,   3,  -1,  -1,  0,  32'hB0, 3,  0};
        vecs[3] = '{32'h4000_0000, 8'd4, 0,  0,  -1,   1,  -1,  0,  32'hC0, 4,  1};
        vecs[4] = '{32'h4000_0010, 8'd4, 1,  0,  -1,  -1,   2,  0,  32'hD0, 4,  1};
        vecs[5] = '{32'h5000_0000, 8'd3, 2,  1,  -1,  -1,  -1,  0,  32'hE0, 0,  0};
        vecs[6] = '{32'h6000_0004, 8'd1, 0,  0,  -1,  -1,  -1,  0,  32'h5A, 1,  0};
        vecs[7] = '{32'h7000_0000, 8'd2, 0,  0,  -1,  -1,  -1,  1,  32'h70, 2,  1};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            mon_fwd = 0;
            mon_err = 0;
            do_req_ar(vecs[i].addr, vecs[i].len, vecs[i].ar_stall, vecs[i].flush_ar);
            run_beats(vecs[i]);
            repeat (2) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("sb_empty", sb.size(), 32'd0);
            chk("idle_rready", {31'd0, bus.rready_o}, 32'd0);
            chk("idle_arvalid", {31'd0, bus.arvalid_o}, 32'd0);
            chk("fwd_count", mon_fwd, vecs[i].exp_fwd);
            chk("err_count", mon_err, vecs[i].exp_err);
            @(posedge clk); #1;
        end

        zero_len_req(32'h0000_1000);

        // reset in the middle of an 8-beat burst
        do_req_ar(32'h7700_0000, 8'd8, 0, 0);
        for (int b = 0; b < 3; b++) begin
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = 32'hF0 + b;
            bus.rresp_i  = 2'b00;
            bus.rlast_i  = 1'b0;
            e.data = 32'hF0 + b;
            e.err  = 1'b0;
            e.cyc  = cycle;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_sb_empty", sb.size(), 32'd0);
        zero_len_req(32'h0000_2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
